// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer helpers and read-mode constants
package fifo_pkg;

  localparam int PTR_MAX_W      = 32;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Narrower pointers are zero-extended by the caller; leading zeros do not disturb either conversion.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - read-side bundle between controller, memory and consumer
interface fifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH:0]   wptr_gray_sync;
  logic                  rinc;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic                  underflow;

  modport master (
    input  wptr_gray_sync, rinc, mem_rdata,
    output mem_ren, raddr, rptr_gray, rdata, rvalid, empty, almost_empty, rd_level, underflow
  );

  modport slave (
    output wptr_gray_sync, rinc, mem_rdata,
    input  mem_ren, raddr, rptr_gray, rdata, rvalid, empty, almost_empty, rd_level, underflow
  );
endinterface

// File: rtl/fifo_rd_buf.sv
// rtl/fifo_rd_buf.sv - 2-entry in-order output buffer for first-word-fall-through reads
module fifo_rd_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side pointer, flags, level and read-mode datapath
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic           CLK,
  input  logic           RST,
  fifo_rd_ctrl_if.master bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_gray_q, rgray_d;
  logic [PW-1:0] rd_level_q, level_d;
  logic [PW-1:0] wbin;
  logic          empty_q, almost_empty_q;
  logic          pop;

  assign wbin    = PW'(gray2bin(PTR_MAX_W'(bus.wptr_gray_sync)));
  assign rbin_d  = rbin_q + PW'(pop);
  assign rgray_d = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
  // Modular subtraction gives 2^ADDR_WIDTH when the pointers differ only in the MSB.
  assign level_d = wbin - rbin_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rbin_q         <= '0;
      rptr_gray_q    <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      rbin_q         <= rbin_d;
      rptr_gray_q    <= rgray_d;
      rd_level_q     <= level_d;
      empty_q        <= (rgray_d == bus.wptr_gray_sync);
      almost_empty_q <= (level_d <= AE_LIMIT);
    end
  end

  assign bus.mem_ren      = pop;
  assign bus.raddr        = rbin_q[ADDR_WIDTH-1:0];
  assign bus.rptr_gray    = rptr_gray_q;
  assign bus.rd_level     = rd_level_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      logic                  inflight_q;
      logic                  consume;
      logic                  rvalid_w;
      logic [1:0]            buf_count;
      logic [1:0]            occ;
      logic [DATA_WIDTH-1:0] head;

      assign rvalid_w = (buf_count != 2'd0);
      assign consume  = bus.rinc & rvalid_w;
      // Words buffered or on their way after this cycle's consume; fetch only while a slot stays free.
      assign occ      = buf_count + {1'b0, inflight_q} - {1'b0, consume};
      assign pop      = ~RST & ~empty_q & (occ < 2'd2);

      always_ff @(posedge CLK) begin
        if (RST) inflight_q <= 1'b0;
        else     inflight_q <= pop;
      end

      fifo_rd_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (inflight_q),
        .push_data_i (bus.mem_rdata),
        .pop_i       (consume),
        .count_o     (buf_count),
        .head_o      (head)
      );

      assign bus.rvalid    = rvalid_w;
      assign bus.rdata     = head;
      assign bus.underflow = ~RST & bus.rinc & ~rvalid_w;
    end else begin : g_std
      logic rvalid_q;

      assign pop = ~RST & bus.rinc & ~empty_q;

      always_ff @(posedge CLK) begin
        if (RST) rvalid_q <= 1'b0;
        else     rvalid_q <= pop;
      end

      assign bus.rvalid    = rvalid_q;
      assign bus.rdata     = bus.mem_rdata;
      assign bus.underflow = ~RST & bus.rinc & empty_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for standard and FWFT read controllers
module tb_fifo_rd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, rst_f;
  int   errors = 0;
  int   checks = 0;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) s_if ();
  fifo_rd_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) f_if ();

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AE_THRESH(1), .FWFT(0)) u_std (
    .CLK (clk),
    .RST (rst_s),
    .bus (s_if.master)
  );

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AE_THRESH(1), .FWFT(1)) u_fwft (
    .CLK (clk),
    .RST (rst_f),
    .bus (f_if.master)
  );

  // Dual-port memory model: word at address i holds A0+i, data valid the cycle after mem_ren.
  logic [7:0] mem [8];
  logic [7:0] s_rd, f_rd;
  always @(posedge clk) if (s_if.mem_ren) s_rd <= mem[s_if.raddr];
  always @(posedge clk) if (f_if.mem_ren) f_rd <= mem[f_if.raddr];
  assign s_if.mem_rdata = s_rd;
  assign f_if.mem_rdata = f_rd;

  typedef struct packed {
    logic       chk, rst, rinc;
    logic [3:0] wptr;
    logic       mem_ren;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       empty, ae;
    logic [3:0] level;
    logic       rvalid;
    logic [7:0] rdata;
    logic       uf;
  } vec_t;

  vec_t tv[$];

  function automatic void v(input int c, r, ri, w, mr, ra, rp, e, a, l, rv, rd, u);
    tv.push_back('{1'(c), 1'(r), 1'(ri), 4'(w), 1'(mr), 3'(ra), 4'(rp),
                   1'(e), 1'(a), 4'(l), 1'(rv), 8'(rd), 1'(u)});
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int npulse;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    rst_s = 1'b1; rst_f = 1'b1;
    s_if.rinc = 1'b0; s_if.wptr_gray_sync = '0;
    f_if.rinc = 1'b0; f_if.wptr_gray_sync = '0;

    // chk rst rinc wptr | mem_ren raddr rptr empty ae level rvalid rdata uf
    v(0,1,1,'b0000, 0,0,'b0000,1,1,0,0,0,0);
    v(1,1,1,'b0000, 0,0,'b0000,1,1,0,0,0,0);
    v(1,0,0,'b0010, 0,0,'b0000,1,1,0,0,0,0);
    v(1,0,1,'b0010, 1,0,'b0000,0,0,3,0,0,0);
    v(1,0,1,'b0010, 1,1,'b0001,0,0,2,1,'hA0,0);
    v(1,0,1,'b0010, 1,2,'b0011,0,1,1,1,'hA1,0);
    v(1,0,1,'b0010, 0,3,'b0010,1,1,0,1,'hA2,1);
    v(1,0,0,'b0010, 0,3,'b0010,1,1,0,0,0,0);
    // full FIFO, drain across the MSB wrap, then three more words
    v(0,1,0,'b0000, 0,0,'b0000,1,1,0,0,0,0);
    v(1,1,0,'b0000, 0,0,'b0000,1,1,0,0,0,0);
    v(1,0,0,'b1100, 0,0,'b0000,1,1,0,0,0,0);
    v(1,0,1,'b1100, 1,0,'b0000,0,0,8,0,0,0);
    v(1,0,1,'b1100, 1,1,'b0001,0,0,7,1,'hA0,0);
    v(1,0,1,'b1100, 1,2,'b0011,0,0,6,1,'hA1,0);
    v(1,0,1,'b1100, 1,3,'b0010,0,0,5,1,'hA2,0);
    v(1,0,1,'b1100, 1,4,'b0110,0,0,4,1,'hA3,0);
    v(1,0,1,'b1100, 1,5,'b0111,0,0,3,1,'hA4,0);
    v(1,0,1,'b1100, 1,6,'b0101,0,0,2,1,'hA5,0);
    v(1,0,1,'b1100, 1,7,'b0100,0,1,1,1,'hA6,0);
    v(1,0,0,'b1100, 0,0,'b1100,1,1,0,1,'hA7,0);
    v(1,0,0,'b1110, 0,0,'b1100,1,1,0,0,0,0);
    v(1,0,1,'b1110, 1,0,'b1100,0,0,3,0,0,0);
    v(1,0,1,'b1110, 1,1,'b1101,0,0,2,1,'hA0,0);
    v(1,0,1,'b1110, 1,2,'b1111,0,1,1,1,'hA1,0);
    v(1,0,0,'b1110, 0,3,'b1110,1,1,0,1,'hA2,0);

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      rst_s = tv[i].rst;
      s_if.rinc = tv[i].rinc;
      s_if.wptr_gray_sync = tv[i].wptr;
      #1;
      if (tv[i].chk) begin
        check("std_mem_ren", i, 32'(s_if.mem_ren),      32'(tv[i].mem_ren));
        check("std_raddr",   i, 32'(s_if.raddr),        32'(tv[i].raddr));
        check("std_rptr",    i, 32'(s_if.rptr_gray),    32'(tv[i].rptr));
        check("std_empty",   i, 32'(s_if.empty),        32'(tv[i].empty));
        check("std_ae",      i, 32'(s_if.almost_empty), 32'(tv[i].ae));
        check("std_level",   i, 32'(s_if.rd_level),     32'(tv[i].level));
        check("std_rvalid",  i, 32'(s_if.rvalid),       32'(tv[i].rvalid));
        check("std_uf",      i, 32'(s_if.underflow),    32'(tv[i].uf));
        if (tv[i].rvalid) check("std_rdata", i, 32'(s_if.rdata), 32'(tv[i].rdata));
      end
      tick();
    end

    // FWFT throughput: 4 words, consumer always ready
    rst_f = 1'b1; f_if.rinc = 1'b1; f_if.wptr_gray_sync = 4'b0000;
    tick(); tick();
    #1;
    check("fw_rst_rvalid", 0, 32'(f_if.rvalid),    32'(0));
    check("fw_rst_empty",  0, 32'(f_if.empty),     32'(1));
    check("fw_rst_ae",     0, 32'(f_if.almost_empty), 32'(1));
    check("fw_rst_mren",   0, 32'(f_if.mem_ren),   32'(0));
    check("fw_rst_uf",     0, 32'(f_if.underflow), 32'(0));
    check("fw_rst_rptr",   0, 32'(f_if.rptr_gray), 32'(0));
    rst_f = 1'b0; f_if.wptr_gray_sync = 4'b0110;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("fw_tp_mren",   c, 32'(f_if.mem_ren),   32'(c >= 1 && c <= 4));
      check("fw_tp_rvalid", c, 32'(f_if.rvalid),    32'(c >= 3 && c <= 6));
      check("fw_tp_uf",     c, 32'(f_if.underflow), 32'(!(c >= 3 && c <= 6)));
      if (c >= 3 && c <= 6) check("fw_tp_rdata", c, 32'(f_if.rdata), 32'(8'hA0 + 8'(c - 3)));
      tick();
    end

    // FWFT backpressure: only two words prefetched, then drain in order
    rst_f = 1'b1; f_if.rinc = 1'b0; f_if.wptr_gray_sync = 4'b0000;
    tick(); tick();
    rst_f = 1'b0; f_if.wptr_gray_sync = 4'b0110;
    npulse = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (f_if.mem_ren) npulse++;
      if (c == 1) check("fw_bp_level4", c, 32'(f_if.rd_level), 32'(4));
      tick();
    end
    #1;
    check("fw_bp_pulses", 0, 32'(npulse),          32'(2));
    check("fw_bp_level2", 0, 32'(f_if.rd_level),  32'(2));
    check("fw_bp_rvalid", 0, 32'(f_if.rvalid),    32'(1));
    check("fw_bp_rdata",  0, 32'(f_if.rdata),     32'(8'hA0));
    check("fw_bp_empty",  0, 32'(f_if.empty),     32'(0));
    f_if.rinc = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("fw_dr_rvalid", c, 32'(f_if.rvalid), 32'(c < 4));
      if (c < 4) check("fw_dr_rdata", c, 32'(f_if.rdata), 32'(8'hA0 + 8'(c)));
      tick();
    end

    // Reset with one word buffered and one in flight
    rst_f = 1'b1; f_if.rinc = 1'b0; f_if.wptr_gray_sync = 4'b0000;
    tick(); tick();
    rst_f = 1'b0; f_if.wptr_gray_sync = 4'b0110;
    tick(); tick(); tick();
    #1;
    check("fw_mr_pre_rvalid", 0, 32'(f_if.rvalid), 32'(1));
    check("fw_mr_pre_rdata",  0, 32'(f_if.rdata),  32'(8'hA0));
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0; f_if.wptr_gray_sync = 4'b0000;
    #1;
    check("fw_mr_rvalid", 0, 32'(f_if.rvalid),    32'(0));
    check("fw_mr_empty",  0, 32'(f_if.empty),     32'(1));
    check("fw_mr_rptr",   0, 32'(f_if.rptr_gray), 32'(0));
    check("fw_mr_level",  0, 32'(f_if.rd_level),  32'(0));
    for (int c = 1; c < 4; c++) begin
      tick();
      #1;
      check("fw_mr_late_rvalid", c, 32'(f_if.rvalid),  32'(0));
      check("fw_mr_late_mren",   c, 32'(f_if.mem_ren), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
